// File: rtl/cpu_run_controller_if.sv
// rtl/cpu_run_controller_if.sv - board/core signal bundle for the run controller
interface cpu_run_controller_if;
    logic [1:0]  run_mode;
    logic        step_button;
    logic        bp_enable;
    logic [31:0] bp_address;
    logic [31:0] program_counter;
    logic        cpu_step_en;
    logic        cpu_halted;
    logic [31:0] step_count;
    logic [1:0]  run_state;

    // Controller side: consumes switches/button/PC, produces the step enable and status.
    modport master (
        input  run_mode,
        input  step_button,
        input  bp_enable,
        input  bp_address,
        input  program_counter,
        output cpu_step_en,
        output cpu_halted,
        output step_count,
        output run_state
    );

    // Board/core side: drives switches/button/PC, observes the step enable and status.
    modport slave (
        output run_mode,
        output step_button,
        output bp_enable,
        output bp_address,
        output program_counter,
        input  cpu_step_en,
        input  cpu_halted,
        input  step_count,
        input  run_state
    );
endinterface

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - halt/run/single-step/breakpoint sequencer for the core clock enable
module cpu_run_controller #(
    parameter int DIV_LOG2  = 20,
    parameter int DB_CYCLES = 50000
) (
    input logic                  clock,
    input logic                  reset,
    cpu_run_controller_if.master bus
);
    // Debounce counter only has to reach DB_CYCLES-1 before the level is accepted.
    localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        HALT  = 2'b00,
        RUN   = 2'b01,
        STEP  = 2'b10,
        BREAK = 2'b11
    } state_t;

    state_t              state;
    logic [DIV_LOG2-1:0] div_count;
    logic                tick;
    logic [1:0]          sync;
    logic                stable;
    logic [DB_W-1:0]     db_count;
    logic                db_done;
    logic                press;
    logic                bp_hit;
    logic                step_en;
    logic [31:0]         step_count;

    // Free-running divider; one run tick whenever it sits at all-ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            div_count <= '0;
        end else begin
            div_count <= div_count + 1'b1;
        end
    end

    assign tick = &div_count;

    // Button synchroniser and debouncer: the stable level only follows after DB_CYCLES differing cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync     <= '0;
            stable   <= 1'b0;
            db_count <= '0;
        end else begin
            sync <= {sync[0], bus.step_button};
            if (sync[1] != stable) begin
                if (db_done) begin
                    stable   <= sync[1];
                    db_count <= '0;
                end else begin
                    db_count <= db_count + 1'b1;
                end
            end else begin
                db_count <= '0;
            end
        end
    end

    // The press fires in the same cycle the stable level is about to rise.
    assign db_done = (sync[1] != stable) && (db_count == DB_LAST);
    assign press   = db_done && sync[1];
    assign bp_hit  = (bus.run_mode == 2'b11) && bus.bp_enable &&
                     (bus.program_counter == bus.bp_address);

    // Run-state machine and registered step pulse; a pulse decided here survives a later mode change.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= HALT;
            step_en <= 1'b0;
        end else begin
            step_en <= ((state == RUN) && tick && !bp_hit) || ((state == STEP) && press);
            case (bus.run_mode)
                2'b00:   state <= HALT;
                2'b01:   state <= RUN;
                2'b10:   state <= STEP;
                default: begin
                    if ((state == BREAK) || ((state == RUN) && tick && bp_hit)) begin
                        state <= BREAK;
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    // Retired-step counter, wraps naturally at 32 bits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            step_count <= '0;
        end else if (step_en) begin
            step_count <= step_count + 32'd1;
        end
    end

    assign bus.cpu_step_en = step_en;
    assign bus.cpu_halted  = (state == HALT) || (state == BREAK);
    assign bus.step_count  = step_count;
    assign bus.run_state   = state;
endmodule
